// File: rtl/nand_op_sequencer.sv
// Bit-serial NAND/AND/OR/XOR engine. One shared nand_gate does every result-bit evaluation.
// Optional NAND-evaluation counter enabled by defining NAND_SEQ_STATS_EN.

module nand_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module nand_op_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef NAND_SEQ_STATS_EN
    ,
    output logic [15:0]      eval_count
`endif
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [1:0]       op_q, step_q;
    logic [IW-1:0]    idx_q;
    logic             t_q, x_q, u_q;

    logic abit, bbit;
    logic ga, gb, gy;

    assign abit = a_q[idx_q];
    assign bbit = b_q[idx_q];

    nand_gate u_nand (
        .a (ga),
        .b (gb),
        .y (gy)
    );

    // Gate input mux. Temps hold intermediates: OR keeps y in t; XOR keeps v in x.
    always_comb begin
        ga = abit;
        gb = bbit;
        unique case (op_q)
            2'b00: ;
            2'b01: begin
                if (step_q != 2'd0) begin
                    ga = t_q;
                    gb = t_q;
                end
            end
            2'b10: begin
                case (step_q)
                    2'd0:    begin ga = abit; gb = abit; end
                    2'd1:    begin ga = bbit; gb = bbit; end
                    default: begin ga = x_q;  gb = t_q;  end
                endcase
            end
            2'b11: begin
                case (step_q)
                    2'd0:    begin ga = abit; gb = bbit; end
                    2'd1:    begin ga = abit; gb = t_q;  end
                    2'd2:    begin ga = bbit; gb = t_q;  end
                    default: begin ga = u_q;  gb = x_q;  end
                endcase
            end
        endcase
    end

    // The last step index of a bit equals the op encoding (S(op) - 1 == op).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            op_q    <= 2'b00;
            step_q  <= 2'd0;
            idx_q   <= '0;
            t_q     <= 1'b0;
            x_q     <= 1'b0;
            u_q     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
`ifdef NAND_SEQ_STATS_EN
            eval_count <= 16'h0000;
`endif
        end else begin
            // Outputs are registered from the current state, one cycle behind it.
            busy <= (state_q != StIdle);
            done <= (state_q == StDone);
            if (state_q == StDone) begin
                result <= acc_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        step_q  <= 2'd0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
`ifdef NAND_SEQ_STATS_EN
                    if (eval_count != 16'hFFFF) begin
                        eval_count <= eval_count + 16'd1;
                    end
`endif
                    unique case (op_q)
                        2'b01: if (step_q == 2'd0) t_q <= gy;
                        2'b10: begin
                            if (step_q == 2'd0) x_q <= gy;
                            if (step_q == 2'd1) t_q <= gy;
                        end
                        2'b11: begin
                            if (step_q == 2'd0) t_q <= gy;
                            if (step_q == 2'd1) u_q <= gy;
                            if (step_q == 2'd2) x_q <= gy;
                        end
                        default: ;
                    endcase
                    if (step_q == op_q) begin
                        acc_q[idx_q] <= gy;
                        step_q       <= 2'd0;
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer (WIDTH=8); stats checks build only with NAND_SEQ_STATS_EN.

module tb_nand_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] result;
`ifdef NAND_SEQ_STATS_EN
    logic [15:0] eval_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] model_result = 8'h00;

    always #5 clk = ~clk;

    nand_op_sequencer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result)
`ifdef NAND_SEQ_STATS_EN
        ,
        .eval_count (eval_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one op, checking busy/done/result every cycle through busy falling.
    task automatic run_op(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] exp, input bit inject, input string tag);
        int n;
        n = 8 * (int'(o) + 1);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; op = ~o;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            chk($sformatf("%s busy k=%0d", tag, k), busy, k <= n + 1);
            chk($sformatf("%s done k=%0d", tag, k), done, k == n + 1);
            chk($sformatf("%s result k=%0d", tag, k), result, (k <= n) ? model_result : exp);
            if (inject && (k == 3 || k == 10)) begin
                start = 1'b1; op = 2'b11; a = 8'h5A; b = 8'hC3;
            end else begin
                start = 1'b0;
            end
        end
        model_result = exp;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = 2'b01; a = 8'hFF; b = 8'hFF;

        // Reset held two cycles with start asserted
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("reset busy", busy, 1'b0);
            chk("reset done", done, 1'b0);
            chk("reset result", result, 8'h00);
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post-reset idle busy", busy, 1'b0);
        end

        run_op(2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, "and");
        run_op(2'b11, 8'hA5, 8'hFF, 8'h5A, 1'b0, "xor");
        run_op(2'b10, 8'h0F, 8'h30, 8'h3F, 1'b0, "or");
        run_op(2'b00, 8'h00, 8'hFF, 8'hFF, 1'b0, "nand");

        // Starts during RUN must be ignored
        run_op(2'b01, 8'hF0, 8'h3C, 8'h30, 1'b1, "and-ignored");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("no second op busy", busy, 1'b0);
            chk("no second op done", done, 1'b0);
        end

        // Reset at RUN cycle 5 of an XOR
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 8'hA5; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        chk("midrun busy before rst", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun rst busy", busy, 1'b0);
        chk("midrun rst done", done, 1'b0);
        chk("midrun rst result", result, 8'h00);
        model_result = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("after abort done", done, 1'b0);
            chk("after abort busy", busy, 1'b0);
        end

        run_op(2'b11, 8'h3C, 8'h0F, 8'h33, 1'b0, "xor-recover");

`ifdef NAND_SEQ_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_result = 8'h00;
        chk("stats reset", eval_count, 16'h0000);
        run_op(2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, "stats-and");
        run_op(2'b11, 8'hA5, 8'hFF, 8'h5A, 1'b0, "stats-xor");
        chk("stats and+xor", eval_count, 16'd48);
        begin
            int guard = 0;
            while (eval_count != 16'hFFFF && guard < 2100) begin
                @(negedge clk);
                start = 1'b1; op = 2'b11; a = 8'h12; b = 8'h34;
                @(negedge clk);
                start = 1'b0;
                repeat (33) @(negedge clk);
                guard++;
            end
            chk("stats saturation reached", eval_count, 16'hFFFF);
        end
        model_result = 8'h26;
        run_op(2'b11, 8'h12, 8'h34, 8'h26, 1'b0, "stats-sat");
        chk("stats stays saturated", eval_count, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
